// File: rtl/keypad_pkg.sv
// Shared types and constant tables for the keypad scan controller and digit display.
// Key map is indexed [column][row] with column 0 = C1 and row 0 = R1.
package keypad_pkg;

    typedef enum logic [1:0] {
        ResNone,
        ResKey,
        ResMulti
    } res_kind_e;

    // code is kept at zero unless kind is ResKey so whole-struct compares are meaningful
    typedef struct packed {
        res_kind_e  kind;
        logic [3:0] code;
    } frame_res_t;

    localparam frame_res_t RES_NONE = '{kind: ResNone, code: 4'h0};

    typedef enum logic [1:0] {
        StDrive,
        StSample,
        StEval
    } scan_state_e;

    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'hF},
        '{4'h2, 4'h5, 4'h8, 4'h0},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    localparam logic [3:0] COL_DRIVE [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Active-high {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Returns the active-low segment drive for a hex value
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return ~SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a non-MULTI result must repeat DEBOUNCE_FRAMES times before it
// becomes the stable result; a change of stable result to a key is reported as a press.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       eval,
    input  frame_res_t res,
    output frame_res_t stable,
    output logic       press
);

    localparam logic [3:0] CntMax = 4'(DEBOUNCE_FRAMES);

    frame_res_t cand_q, cand_d;
    frame_res_t stable_q, stable_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press    = 1'b0;
        if (eval) begin
            if (res.kind == ResMulti) begin
                cnt_d = '0;
            end else if (res == cand_q) begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cand_d = res;
                cnt_d  = 4'd1;
            end
            if (cnt_d == CntMax && cand_d != stable_q) begin
                stable_d = cand_d;
                press    = (cand_d.kind == ResKey);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q   <= RES_NONE;
            stable_q <= RES_NONE;
            cnt_q    <= '0;
        end else begin
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Exposes the result including this EVAL's update so the caller can act on the same edge
    assign stable = stable_d;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// 4x4 keypad scanner with frame debounce, writing accepted keys into four cursor-addressed
// seven-segment digit slots.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 100000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    input  logic       en,
    input  logic       clr,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [1:0] cursor,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3
);

    localparam int unsigned CntW = 20;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 2);

    scan_state_e     state_q, state_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     hits_q, hits_d;
    logic [3:0]      col_q;

    frame_res_t frame_res;
    frame_res_t stable;
    logic       press;
    logic [4:0] hit_cnt;
    logic [3:0] hit_pos;

    logic            key_valid_q;
    logic [3:0]      key_code_q, key_code_d;
    logic [1:0]      cursor_q, cursor_d;
    logic [3:0][6:0] seg_q, seg_d;
    logic [3:0][7:0] hex_all;

    // hits bit {col,row} is set when that row read low while that column was driven
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        cnt_d     = cnt_q;
        hits_d    = hits_q;
        unique case (state_q)
            StDrive: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSample: begin
                for (int r = 0; r < 4; r++) begin
                    hits_d[{col_idx_q, 2'(r)}] = ~row[2'(3 - r)];
                end
                if (col_idx_q == 2'd3) begin
                    state_d = StEval;
                end else begin
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = StDrive;
                end
            end
            StEval: begin
                col_idx_d = 2'd0;
                state_d   = StDrive;
            end
            default: begin
                col_idx_d = 2'd0;
                cnt_d     = '0;
                state_d   = StDrive;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StDrive;
            col_idx_q <= 2'd0;
            cnt_q     <= '0;
            hits_q    <= '0;
            col_q     <= COL_DRIVE[0];
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            cnt_q     <= cnt_d;
            hits_q    <= hits_d;
            col_q     <= COL_DRIVE[col_idx_d];
        end
    end

    always_comb begin
        hit_cnt = '0;
        hit_pos = '0;
        for (int i = 0; i < 16; i++) begin
            if (hits_q[i]) begin
                hit_cnt = hit_cnt + 5'd1;
                hit_pos = 4'(i);
            end
        end
        frame_res = RES_NONE;
        if (hit_cnt == 5'd1) begin
            frame_res = '{kind: ResKey, code: KEY_MAP[hit_pos[3:2]][hit_pos[1:0]]};
        end else if (hit_cnt > 5'd1) begin
            frame_res.kind = ResMulti;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .eval  (state_q == StEval),
        .res   (frame_res),
        .stable(stable),
        .press (press)
    );

    // clr wins over a coincident write; the press itself is still reported
    always_comb begin
        key_code_d = key_code_q;
        cursor_d   = cursor_q;
        seg_d      = seg_q;
        if (press) begin
            key_code_d = stable.code;
        end
        if (clr) begin
            cursor_d = 2'd0;
            seg_d    = {4{SEG_BLANK}};
        end else if (press && en) begin
            seg_d[cursor_q] = hex_to_seg(stable.code);
            cursor_d        = cursor_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            cursor_q    <= 2'd0;
            seg_q       <= {4{SEG_BLANK}};
        end else begin
            key_valid_q <= press;
            key_code_q  <= key_code_d;
            cursor_q    <= cursor_d;
            seg_q       <= seg_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hex_all[i] = {~(en && (cursor_q == 2'(i))), seg_q[i]};
        end
    end

    assign col       = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign cursor    = cursor_q;
    assign hex0      = hex_all[0];
    assign hex1      = hex_all[1];
    assign hex2      = hex_all[2];
    assign hex3      = hex_all[3];

endmodule
